// File: rtl/dc_blocker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dc_blocker_pkg
// Purpose  : Shared width helpers, output saturation and coefficient
//            constants for the multi-channel DC blocker.
// Contents : calc_idw / calc_out_dw / calc_ch_w  - derived widths
//            saturate                            - clamp to a signed width
//            ALPHA_0999                          - alpha ~0.999 at COEF_DW=16
// Revision : 1.0 - initial release
// ============================================================================
package dc_blocker_pkg;

  // Pole ~0.999 (Q0.16) for the usual receiver front-end setting.
  localparam logic [15:0] ALPHA_0999 = 16'hFFBE;

  // Internal state width: input + fractional bits + sign + one headroom bit.
  function automatic int calc_idw(input int input_dw, input int frac_bits);
    return input_dw + frac_bits + 2;
  endfunction

  // Output width: input + output fractional bits + sign.
  function automatic int calc_out_dw(input int input_dw, input int out_frac_bits);
    return input_dw + out_frac_bits + 1;
  endfunction

  // Channel index width, never narrower than one bit.
  function automatic int calc_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Clamp a wide signed value into the signed range of a w-bit result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int                 w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dc_blocker_sat.sv
`default_nettype none
// ============================================================================
// Module   : dc_blocker_sat
// Purpose  : Arithmetic right shift (floor) of an internal fixed-point value
//            followed by saturation to a signed output width. Purely
//            combinational; shared by the filter and bypass output paths.
// Ports    : i_data  in  IN_W   signed internal value
//            o_data  out OUT_W  shifted, clamped value
//            o_sat   out 1      clamping occurred
// Revision : 1.0 - initial release
// ============================================================================
module dc_blocker_sat
  import dc_blocker_pkg::*;
#(
  parameter int IN_W  = 22,
  parameter int SHIFT = 4,
  parameter int OUT_W = 17
) (
  input  logic signed [IN_W-1:0]  i_data,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_sat
);

  logic signed [IN_W-1:0] w_shifted;
  logic signed [63:0]     w_wide;
  logic signed [63:0]     w_clamped;

  assign w_shifted = i_data >>> SHIFT;
  assign w_wide    = 64'(w_shifted);
  assign w_clamped = saturate(w_wide, OUT_W);
  assign o_data    = w_clamped[OUT_W-1:0];
  assign o_sat     = (w_clamped != w_wide);

endmodule
`default_nettype wire

// File: rtl/dc_blocker_mc.sv
`default_nettype none
// ============================================================================
// Module   : dc_blocker_mc
// Purpose  : Time-multiplexed multi-channel DC-blocking high-pass filter,
//            y[n] = x[n] - x[n-1] + alpha*y[n-1], independent state per
//            channel, fixed two-cycle latency, one sample per cycle.
// Ports    : clk, rst (async, active-high)
//            en_i       accept enable (0 drops samples, freezes state)
//            bypass_i   pass input through, state not written
//            clear_i    zero all channel state at this edge
//            alpha_i    unsigned Q0.COEF_DW pole, sampled per sample
//            valid_i / chan_i / data_i   input sample
//            valid_o / chan_o / data_o / sat_o   output sample
//            chan_err_o pulse for a valid sample on a nonexistent channel
// Revision : 1.0 - initial release
// ============================================================================
module dc_blocker_mc
  import dc_blocker_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int INPUT_DW           = 12,
  parameter int INPUT_SIGNED       = 0,
  parameter int INTERNAL_FRAC_BITS = 8,
  parameter int OUTPUT_FRAC_BITS   = 4,
  parameter int COEF_DW            = 16
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 en_i,
  input  logic                                                 bypass_i,
  input  logic                                                 clear_i,
  input  logic [COEF_DW-1:0]                                   alpha_i,
  input  logic                                                 valid_i,
  input  logic [calc_ch_w(NUM_CH)-1:0]                         chan_i,
  input  logic [INPUT_DW-1:0]                                  data_i,
  output logic                                                 valid_o,
  output logic [calc_ch_w(NUM_CH)-1:0]                         chan_o,
  output logic [calc_out_dw(INPUT_DW, OUTPUT_FRAC_BITS)-1:0]   data_o,
  output logic                                                 sat_o,
  output logic                                                 chan_err_o
);

  localparam int IDW    = calc_idw(INPUT_DW, INTERNAL_FRAC_BITS);
  localparam int OUT_DW = calc_out_dw(INPUT_DW, OUTPUT_FRAC_BITS);
  localparam int CH_W   = calc_ch_w(NUM_CH);
  localparam int SHIFT  = INTERNAL_FRAC_BITS - OUTPUT_FRAC_BITS;

  // Per-channel history.
  logic signed [IDW-1:0] r_x1 [NUM_CH];
  logic signed [IDW-1:0] r_y  [NUM_CH];

  // Stage-1 pipeline registers.
  logic                  r_s1_valid;
  logic [CH_W-1:0]       r_s1_ch;
  logic                  r_s1_byp;
  logic signed [IDW-1:0] r_s1_x;
  logic signed [IDW-1:0] r_s1_x1;
  logic signed [IDW-1:0] r_s1_p;

  logic                  w_ch_ok;
  logic                  w_accept;
  logic [CH_W-1:0]       w_rd_idx;
  logic                  w_fill;
  logic [IDW-1:0]        w_x_zext;
  logic signed [IDW-1:0] w_x_ext;
  logic                  w_s2_wr;
  logic                  w_fwd;
  logic signed [IDW-1:0] w_x1_rd;
  logic signed [IDW-1:0] w_y_rd;
  logic signed [COEF_DW:0]  w_alpha_s;
  logic signed [2*IDW-1:0]  w_prod;
  logic signed [IDW-1:0] w_p;
  logic signed [IDW-1:0] w_y_new;
  logic signed [OUT_DW-1:0] w_filt_data;
  logic signed [OUT_DW-1:0] w_byp_data;
  logic                  w_filt_sat;
  logic                  w_byp_sat;

  assign w_ch_ok  = (32'(chan_i) < NUM_CH);
  assign w_accept = valid_i && en_i && w_ch_ok;
  // Keep the array read inside the populated range even for rejected samples.
  assign w_rd_idx = w_ch_ok ? chan_i : '0;

  // Input extension: the two top bits beyond the shifted sample are the
  // sign/headroom bits, filled with the sign only for two's-complement input.
  assign w_fill   = (INPUT_SIGNED != 0) ? data_i[INPUT_DW-1] : 1'b0;
  assign w_x_zext = {{(IDW-INPUT_DW){w_fill}}, data_i};
  assign w_x_ext  = w_x_zext << INTERNAL_FRAC_BITS;

  // Stage 2: new output and state update for the sample registered last cycle.
  assign w_y_new = r_s1_x - r_s1_x1 + r_s1_p;
  assign w_s2_wr = r_s1_valid && !r_s1_byp;

  // When the sample behind us targets the channel being written this edge,
  // the array is one update stale, so take the values straight from stage 2.
  // A clear at the same edge wipes everything, including that update.
  assign w_fwd   = w_s2_wr && (r_s1_ch == chan_i) && !clear_i;
  assign w_x1_rd = clear_i ? '0 : (w_fwd ? r_s1_x  : r_x1[w_rd_idx]);
  assign w_y_rd  = clear_i ? '0 : (w_fwd ? w_y_new : r_y[w_rd_idx]);

  // alpha*y at double width, floor shift by COEF_DW, truncated back to IDW.
  assign w_alpha_s = {1'b0, alpha_i};
  assign w_prod    = (2*IDW)'(w_y_rd) * (2*IDW)'(w_alpha_s);
  assign w_p       = IDW'(w_prod >>> COEF_DW);

  dc_blocker_sat #(
    .IN_W  (IDW),
    .SHIFT (SHIFT),
    .OUT_W (OUT_DW)
  ) u_sat_filt (
    .i_data (w_y_new),
    .o_data (w_filt_data),
    .o_sat  (w_filt_sat)
  );

  dc_blocker_sat #(
    .IN_W  (IDW),
    .SHIFT (SHIFT),
    .OUT_W (OUT_DW)
  ) u_sat_byp (
    .i_data (r_s1_x),
    .o_data (w_byp_data),
    .o_sat  (w_byp_sat)
  );

  // Stage 1 registers and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_byp   <= 1'b0;
      r_s1_x     <= '0;
      r_s1_x1    <= '0;
      r_s1_p     <= '0;
      chan_err_o <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      chan_err_o <= valid_i && en_i && !w_ch_ok;
      if (w_accept) begin
        r_s1_ch  <= chan_i;
        r_s1_byp <= bypass_i;
        r_s1_x   <= w_x_ext;
        r_s1_x1  <= w_x1_rd;
        r_s1_p   <= w_p;
      end
    end
  end

  // Channel state: clear has priority over the stage-2 write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_x1[c] <= '0;
        r_y[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (clear_i) begin
          r_x1[c] <= '0;
          r_y[c]  <= '0;
        end else if (w_s2_wr && (r_s1_ch == CH_W'(c))) begin
          r_x1[c] <= r_s1_x;
          r_y[c]  <= w_y_new;
        end
      end
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      chan_o  <= '0;
      data_o  <= '0;
      sat_o   <= 1'b0;
    end else begin
      valid_o <= r_s1_valid;
      if (r_s1_valid) begin
        chan_o <= r_s1_ch;
        data_o <= r_s1_byp ? w_byp_data : w_filt_data;
        sat_o  <= r_s1_byp ? 1'b0 : w_filt_sat;
      end else begin
        sat_o  <= 1'b0;
      end
    end
  end

  // The bypass path never clamps at these widths; its flag is intentionally
  // not propagated.
  logic w_unused;
  assign w_unused = w_byp_sat;

endmodule
`default_nettype wire
